// File: rtl/qadd_g_engine.sv
// qadd_g_engine: vector sign-magnitude fixed-point adder.
//
// Two strobed operand vectors are queued in per-operand skew FIFOs, re-paired
// oldest-first, then summed lane by lane through a two-stage pipeline.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous clear of FIFOs, pipeline and err_sticky
//   qadd_a_g / qadd_a_g_en  operand A vector and strobe
//   qadd_b_g / qadd_b_g_en  operand B vector and strobe
//   qadd_c_g                result vector (holds while qadd_c_g_valid is low)
//   qadd_c_g_valid          one-cycle strobe per result
//   lane_ovf                per-lane magnitude overflow, qualified by qadd_c_g_valid
//   err_sticky              set when an operand is dropped on a full FIFO
//
// Build option: define QADD_SAT_EN to saturate overflowing lanes to the largest
// magnitude; otherwise the magnitude wraps. lane_ovf reports overflow either way.
module qadd_g_engine #(
   parameter int unsigned QADD_WIDTH      = 64,
   parameter int unsigned QADD_Q          = 15,
   parameter int unsigned LANES           = 4,
   parameter int unsigned BRAM_DATA_WIDTH = QADD_WIDTH * LANES,
   parameter int unsigned SKEW_DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [BRAM_DATA_WIDTH-1:0] qadd_a_g,
   input  logic                       qadd_a_g_en,
   input  logic [BRAM_DATA_WIDTH-1:0] qadd_b_g,
   input  logic                       qadd_b_g_en,
   output logic [BRAM_DATA_WIDTH-1:0] qadd_c_g,
   output logic                       qadd_c_g_valid,
   output logic [LANES-1:0]           lane_ovf,
   output logic                       err_sticky
);

   localparam int unsigned M  = QADD_WIDTH - 1;
   localparam int unsigned PW = $clog2(SKEW_DEPTH);

   // Addition does not depend on the binary point; QADD_Q is only range-checked.
   if (QADD_Q >= QADD_WIDTH - 1) begin : g_bad_q
      $error("QADD_Q must be smaller than QADD_WIDTH-1");
   end
   if (SKEW_DEPTH < 2 || (SKEW_DEPTH & (SKEW_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("SKEW_DEPTH must be a power of two and at least 2");
   end

   // ---------------------------------------------------------------- skew FIFOs
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [BRAM_DATA_WIDTH-1:0] fa_mem [SKEW_DEPTH];
   logic [BRAM_DATA_WIDTH-1:0] fb_mem [SKEW_DEPTH];
   logic [PW:0] fa_wr_q, fa_rd_q, fb_wr_q, fb_rd_q;
   logic        fa_empty, fa_full, fb_empty, fb_full;
   logic        pop, push_a, push_b, drop;

   assign fa_empty = (fa_wr_q == fa_rd_q);
   assign fb_empty = (fb_wr_q == fb_rd_q);
   assign fa_full  = (fa_wr_q[PW] != fa_rd_q[PW]) && (fa_wr_q[PW-1:0] == fa_rd_q[PW-1:0]);
   assign fb_full  = (fb_wr_q[PW] != fb_rd_q[PW]) && (fb_wr_q[PW-1:0] == fb_rd_q[PW-1:0]);

   assign pop    = !flush && !fa_empty && !fb_empty;
   // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
   assign push_a = !flush && qadd_a_g_en && (!fa_full || pop);
   assign push_b = !flush && qadd_b_g_en && (!fb_full || pop);
   assign drop   = !flush && ((qadd_a_g_en && fa_full && !pop) ||
                              (qadd_b_g_en && fb_full && !pop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fa_wr_q <= '0;
         fa_rd_q <= '0;
         fb_wr_q <= '0;
         fb_rd_q <= '0;
      end else if (flush) begin
         fa_wr_q <= '0;
         fa_rd_q <= '0;
         fb_wr_q <= '0;
         fb_rd_q <= '0;
      end else begin
         if (push_a) fa_wr_q <= fa_wr_q + 1'b1;
         if (push_b) fb_wr_q <= fb_wr_q + 1'b1;
         if (pop) begin
            fa_rd_q <= fa_rd_q + 1'b1;
            fb_rd_q <= fb_rd_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push_a) fa_mem[fa_wr_q[PW-1:0]] <= qadd_a_g;
      if (push_b) fb_mem[fb_wr_q[PW-1:0]] <= qadd_b_g;
   end

   logic [BRAM_DATA_WIDTH-1:0] head_a, head_b;
   assign head_a = fa_mem[fa_rd_q[PW-1:0]];
   assign head_b = fb_mem[fb_rd_q[PW-1:0]];

   // ---------------------------------------------------------------- stage 1
   logic                       s1_valid_q;
   logic [BRAM_DATA_WIDTH-1:0] s1_a_q, s1_b_q;
   logic [LANES-1:0]           s1_ge_q, s1_ge_d;

   for (genvar l = 0; l < LANES; l++) begin : g_cmp
      assign s1_ge_d[l] = head_a[l*QADD_WIDTH +: M] >= head_b[l*QADD_WIDTH +: M];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_ge_q    <= '0;
      end else begin
         s1_valid_q <= pop;
         if (pop) begin
            s1_a_q  <= head_a;
            s1_b_q  <= head_b;
            s1_ge_q <= s1_ge_d;
         end
      end
   end

   // ---------------------------------------------------------------- lane math
   logic [BRAM_DATA_WIDTH-1:0] c_d;
   logic [LANES-1:0]           ovf_d;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [M-1:0] ma, mb, mag_sum, mag_dif, mag;
      logic [M:0]   sum;
      logic         sa, sb, same, sign;

      assign ma = s1_a_q[l*QADD_WIDTH +: M];
      assign mb = s1_b_q[l*QADD_WIDTH +: M];
      // A zero magnitude is positive regardless of its sign bit.
      assign sa = s1_a_q[l*QADD_WIDTH + M] & (|ma);
      assign sb = s1_b_q[l*QADD_WIDTH + M] & (|mb);

      assign same = (sa == sb);
      assign sum  = {1'b0, ma} + {1'b0, mb};
`ifdef QADD_SAT_EN
      assign mag_sum = sum[M] ? {M{1'b1}} : sum[M-1:0];
`else
      assign mag_sum = sum[M-1:0];
`endif
      assign mag_dif = s1_ge_q[l] ? (ma - mb) : (mb - ma);
      assign mag     = same ? mag_sum : mag_dif;
      assign sign    = same ? sa : (s1_ge_q[l] ? sa : sb);

      // Wrapped or cancelled results may reach zero; never emit -0.
      assign c_d[l*QADD_WIDTH +: QADD_WIDTH] = {sign & (|mag), mag};
      assign ovf_d[l] = same & sum[M];
   end

   // ---------------------------------------------------------------- stage 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qadd_c_g_valid <= 1'b0;
         qadd_c_g       <= '0;
         lane_ovf       <= '0;
      end else if (flush) begin
         qadd_c_g_valid <= 1'b0;
      end else begin
         qadd_c_g_valid <= s1_valid_q;
         if (s1_valid_q) begin
            qadd_c_g <= c_d;
            lane_ovf <= ovf_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (flush) begin
         err_sticky <= 1'b0;
      end else if (drop) begin
         err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_qadd_g_engine.sv
// Self-checking bench for qadd_g_engine: a queue-based reference model plus a
// per-cycle compare process, and directed literal checks.
module tb_qadd_g_engine;

   localparam int W  = 64;
   localparam int L  = 4;
   localparam int BW = W * L;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [BW-1:0] a_vec = '0, b_vec = '0;
   logic          a_en = 1'b0, b_en = 1'b0;
   logic [BW-1:0] c_vec;
   logic          c_valid;
   logic [L-1:0]  ovf;
   logic          err;

   qadd_g_engine #(
      .QADD_WIDTH      (W),
      .QADD_Q          (15),
      .LANES           (L),
      .BRAM_DATA_WIDTH (BW),
      .SKEW_DEPTH      (D)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .qadd_a_g       (a_vec),
      .qadd_a_g_en    (a_en),
      .qadd_b_g       (b_vec),
      .qadd_b_g_en    (b_en),
      .qadd_c_g       (c_vec),
      .qadd_c_g_valid (c_valid),
      .lane_ovf       (ovf),
      .err_sticky     (err)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nfail = 0;
   int cyc = 0;
   int nres = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Lane sum computed as plain signed integer arithmetic.
   function automatic logic [W-1:0] model_lane(input logic [W-1:0] a, input logic [W-1:0] b,
                                                output logic o);
      logic signed [W+1:0] va, vb, s, m, maxm;
      maxm = $signed({3'b000, {(W-1){1'b1}}});
      va = $signed({3'b000, a[W-2:0]});
      vb = $signed({3'b000, b[W-2:0]});
      if (a[W-1]) va = -va;
      if (b[W-1]) vb = -vb;
      s = va + vb;
      m = (s < 0) ? -s : s;
      o = (m > maxm);
      if (o) begin
`ifdef QADD_SAT_EN
         m = maxm;
`else
         m = m - maxm - 1;
`endif
      end
      return {(s < 0) && (m != 0), m[W-2:0]};
   endfunction

   function automatic logic [BW-1:0] model_vec(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                               output logic [L-1:0] o);
      logic [BW-1:0] r;
      logic          lo;
      for (int l = 0; l < L; l++) begin
         r[l*W +: W] = model_lane(a[l*W +: W], b[l*W +: W], lo);
         o[l] = lo;
      end
      return r;
   endfunction

   typedef struct {
      int            due;
      logic [BW-1:0] c;
      logic [L-1:0]  o;
   } exp_t;

   logic [BW-1:0] qa[$];
   logic [BW-1:0] qb[$];
   exp_t          pend[$];
   logic          exp_err = 1'b0;
   logic [BW-1:0] last_c = '0;
   logic [L-1:0]  last_ovf = '0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            qa.delete();
            qb.delete();
            pend.delete();
            exp_err  = 1'b0;
            last_c   = '0;
            last_ovf = '0;
         end else if (flush) begin
            qa.delete();
            qb.delete();
            pend.delete();
            exp_err = 1'b0;
         end else begin
            if (qa.size() > 0 && qb.size() > 0) begin
               exp_t e;
               logic [BW-1:0] av, bv;
               av = qa.pop_front();
               bv = qb.pop_front();
               e.due = cyc + 2;
               e.c = model_vec(av, bv, e.o);
               pend.push_back(e);
            end
            if (a_en) begin
               if (qa.size() < D) qa.push_back(a_vec);
               else exp_err = 1'b1;
            end
            if (b_en) begin
               if (qb.size() < D) qb.push_back(b_vec);
               else exp_err = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- compare
   initial begin
      forever begin
         @(negedge clk);
         if (c_valid === 1'b1) nres++;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_t e;
            e = pend.pop_front();
            chk("valid_hi", c_valid, 1);
            chk("result", c_vec, e.c);
            chk("lane_ovf", ovf, e.o);
            last_c   = e.c;
            last_ovf = e.o;
         end else begin
            chk("valid_lo", c_valid, 0);
            chk("result_hold", c_vec, last_c);
            chk("ovf_hold", ovf, last_ovf);
         end
         chk("err_sticky", err, exp_err);
      end
   end

   // ---------------------------------------------------------------- stimulus
   function automatic logic [BW-1:0] vec(input logic [63:0] l0, input logic [63:0] l1,
                                         input logic [63:0] l2, input logic [63:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [BW-1:0] mk_a(input int i);
      return vec(64'(i * 4096 + 7), 64'h8000_0000_0000_0010 + 64'(i), 64'(i),
                 64'hC000_0000_0000_0000 + 64'(i));
   endfunction

   function automatic logic [BW-1:0] mk_b(input int i);
      return vec(64'(i * 100), 64'(i + 3), 64'h8000_0000_0000_0000 | 64'(i),
                 64'hC000_0000_0000_0000);
   endfunction

   task automatic drive(input logic ae, input logic [BW-1:0] av, input logic be,
                        input logic [BW-1:0] bv, input logic fl);
      @(posedge clk);
      #1;
      a_en = ae;
      a_vec = av;
      b_en = be;
      b_vec = bv;
      flush = fl;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
`ifdef QADD_SAT_EN
   localparam logic [63:0] OVF_RES = 64'h7FFF_FFFF_FFFF_FFFF;
`else
   localparam logic [63:0] OVF_RES = 64'h7FFF_FFFF_FFFF_FFFE;
`endif

   initial begin
      logic          po;
      logic [63:0]   pr;

      // Pin the model with hand-computed lane results.
      pr = model_lane(64'h8000, 64'h8000, po);
      chk("pin_q15_add", {pr, 63'd0, po}, {64'h1_0000, 63'd0, 1'b0});
      pr = model_lane(64'h8000_0000_0000_0005, 64'h3, po);
      chk("pin_neg5_pos3", pr, 64'h8000_0000_0000_0002);
      pr = model_lane(64'h3, 64'h8000_0000_0000_0003, po);
      chk("pin_cancel", pr, 64'h0);
      pr = model_lane(MAXP, MAXP, po);
      chk("pin_ovf", {pr, 63'd0, po}, {OVF_RES, 63'd0, 1'b1});

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Aligned pair: lane3 adds -0 and +5.
      drive(1'b1, vec(64'h8000, 64'h8000_0000_0000_0005, MAXP, 64'h8000_0000_0000_0000),
            1'b1, vec(64'h8000, 64'h3, MAXP, 64'h5), 1'b0);
      idle(1);
      @(posedge clk); #1;
      chk("lat_t2_valid", c_valid, 0);
      @(posedge clk); #1;
      chk("lat_t3_valid", c_valid, 1);
      chk("lit_lane0", c_vec[63:0], 64'h1_0000);
      chk("lit_lane1", c_vec[127:64], 64'h8000_0000_0000_0002);
      chk("lit_lane2", c_vec[191:128], OVF_RES);
      chk("lit_lane3", c_vec[255:192], 64'h5);
      chk("lit_ovf", ovf, 4'b0100);

      // Cancellation and -0 + -0.
      drive(1'b1, vec(64'h8000_0000_0000_0000, 64'h3, 64'h1, 64'h2),
            1'b1, vec(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0003, 64'h1, 64'h2), 1'b0);
      idle(3);
      chk("lit_cancel_lane1", c_vec[127:64], 64'h0);
      chk("lit_negzero_lane0", c_vec[63:0], 64'h0);
      idle(3);

      // Skewed burst: 4 A strobes, B strobes starting two cycles later.
      for (int i = 0; i < 6; i++)
         drive(i < 4, (i < 4) ? mk_a(i) : '0, i >= 2, (i >= 2) ? mk_b(i - 2) : '0, 1'b0);
      idle(8);
      chk("burst_err", err, 0);

      // Overrun A with no B, then drain with 4 B strobes.
      nres = 0;
      for (int i = 0; i < 5; i++) drive(1'b1, mk_a(i + 10), 1'b0, '0, 1'b0);
      idle(2);
      chk("overrun_err", err, 1);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, mk_b(i + 10), 1'b0);
      idle(8);
      chk("overrun_results", nres, 4);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      idle(1);
      chk("flush_err", err, 0);

      // Strobes under flush are discarded.
      nres = 0;
      drive(1'b1, mk_a(20), 1'b1, mk_b(20), 1'b1);
      idle(6);
      chk("flush_discard", nres, 0);

      // Push into a full A FIFO with a same-cycle pop is accepted.
      for (int i = 0; i < 4; i++) drive(1'b1, mk_a(30 + i), i == 3, mk_b(30), 1'b0);
      drive(1'b1, mk_a(34), 1'b0, '0, 1'b0);
      for (int i = 1; i < 5; i++) drive(1'b0, '0, 1'b1, mk_b(30 + i), 1'b0);
      idle(6);
      chk("full_pop_err", err, 0);

      // Reset in the middle of a streaming burst.
      for (int i = 0; i < 5; i++) drive(1'b1, mk_a(40 + i), 1'b1, mk_b(40 + i), 1'b0);
      chk("stream_valid", c_valid, 1);
      rst_n = 1'b0;
      a_en = 1'b0;
      b_en = 1'b0;
      #1;
      chk("reset_valid_async", c_valid, 0);
      chk("reset_c", c_vec, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(8);
      for (int i = 0; i < 2; i++) drive(1'b1, mk_a(50 + i), 1'b1, mk_b(50 + i), 1'b0);
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
